cpu_0_mul_seq: RTL and testbench

Multicycle 32x32 multiply sequencer for the cpu_0 datapath. Accepts a multiply request from the M stage, forms the full 64-bit product from four 16x16 unsigned partial products accumulated over successive cycles, and returns either the low or the high result word. This covers MUL, MULXUU, MULXSS and MULXSU, including high-word results the single-cycle low-word multiplier cell cannot produce. Sign handling is magnitude-based, with a final 64-bit conditional negate.

---
 rtl/cpu_0_mul_seq.sv | 121 ++++++++++++
 tb/tb_cpu_0_mul_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_0_mul_seq.sv
// cpu_0_mul_seq: multicycle 32x32 multiply sequencer for the M stage.
// Accumulates four 16x16 partial products, then applies a sign fix-up.
module cpu_0_mul_seq #(
  parameter bit FAST_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_mul_start,
  input  logic [1:0]  M_mul_op,
  input  logic [31:0] M_mul_src1,
  input  logic [31:0] M_mul_src2,
  output logic        M_mul_busy,
  output logic        M_mul_done,
  output logic [31:0] M_mul_result
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIX,
    DONE
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SS  = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg;
  logic [63:0] acc;
  logic [1:0]  cnt;

  logic        a_sgn;
  logic        b_sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [15:0] a_half;
  logic [15:0] b_half;
  logic [31:0] pp;
  logic [63:0] pp_sh;
  logic [63:0] fixed;
  logic        acc_last;

  always_comb begin
    a_sgn = M_mul_op[1] & M_mul_src1[31];
    b_sgn = (M_mul_op == OP_SS) & M_mul_src2[31];
    a_abs = a_sgn ? (~M_mul_src1 + 32'd1) : M_mul_src1;
    b_abs = b_sgn ? (~M_mul_src2 + 32'd1) : M_mul_src2;
  end

  // cnt[0] picks the high half of A, cnt[1] the high half of B
  always_comb begin
    a_half = cnt[0] ? a_mag[31:16] : a_mag[15:0];
    b_half = cnt[1] ? b_mag[31:16] : b_mag[15:0];
    pp     = {16'b0, a_half} * {16'b0, b_half};
    unique case (cnt)
      2'd0:    pp_sh = {32'b0, pp};
      2'd3:    pp_sh = {pp, 32'b0};
      default: pp_sh = {16'b0, pp, 16'b0};
    endcase
  end

  always_comb begin
    acc_last = (cnt == 2'd3)
             | (FAST_LOW && op == OP_MUL && cnt == 2'd2);
    fixed    = neg ? (~acc + 64'd1) : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (M_mul_start) state_nxt = ACC;
      ACC:  if (acc_last)    state_nxt = FIX;
      FIX:                   state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op           <= OP_MUL;
      a_mag        <= '0;
      b_mag        <= '0;
      neg          <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      M_mul_result <= '0;
    end else begin
      unique case (state)
        IDLE: if (M_mul_start) begin
          op    <= M_mul_op;
          a_mag <= a_abs;
          b_mag <= b_abs;
          neg   <= a_sgn ^ b_sgn;
          acc   <= '0;
          cnt   <= '0;
        end
        ACC: begin
          acc <= acc + pp_sh;
          cnt <= cnt + 2'd1;
        end
        FIX: M_mul_result <= (op == OP_MUL) ? acc[31:0]
                                            : fixed[63:32];
        default: ;
      endcase
    end
  end

  assign M_mul_busy = (state != IDLE);
  assign M_mul_done = (state == DONE);

endmodule

// File: tb/tb_cpu_0_mul_seq.sv
// tb_cpu_0_mul_seq: drives FAST_LOW=1 and FAST_LOW=0 instances in lockstep
// and checks them against a plain-arithmetic product model.
module tb_cpu_0_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;

  logic        f_busy, f_done;
  logic [31:0] f_res;
  logic        s_busy, s_done;
  logic [31:0] s_res;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] f_prev;
  logic [31:0] s_prev;

  always #5 clk = ~clk;

  cpu_0_mul_seq #(.FAST_LOW(1'b1)) u_fast (
    .clk          (clk),
    .reset        (reset),
    .M_mul_start  (start),
    .M_mul_op     (op),
    .M_mul_src1   (src1),
    .M_mul_src2   (src2),
    .M_mul_busy   (f_busy),
    .M_mul_done   (f_done),
    .M_mul_result (f_res)
  );

  cpu_0_mul_seq #(.FAST_LOW(1'b0)) u_slow (
    .clk          (clk),
    .reset        (reset),
    .M_mul_start  (start),
    .M_mul_op     (op),
    .M_mul_src1   (src1),
    .M_mul_src2   (src2),
    .M_mul_busy   (s_busy),
    .M_mul_done   (s_done),
    .M_mul_result (s_res)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = o[1] ? 64'(signed'(a)) : 64'({32'b0, a});
    sb = (o == 2'b10) ? 64'(signed'(b)) : 64'({32'b0, b});
    p  = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called just after a falling edge; start is sampled in cycle 0.
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit pulse);
    logic [31:0] exp;
    int lat_f;
    exp   = ref_mul(o, a, b);
    lat_f = (o == 2'b00) ? 5 : 6;
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    src1  = $urandom;
    src2  = $urandom;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check($sformatf("fast busy c%0d", n), 32'(f_busy), 32'(n <= lat_f));
      check($sformatf("fast done c%0d", n), 32'(f_done), 32'(n == lat_f));
      check($sformatf("slow busy c%0d", n), 32'(s_busy), 32'(n <= 6));
      check($sformatf("slow done c%0d", n), 32'(s_done), 32'(n == 6));
      check($sformatf("fast res c%0d", n), f_res,
            (n >= lat_f) ? exp : f_prev);
      check($sformatf("slow res c%0d", n), s_res,
            (n >= 6) ? exp : s_prev);
      if (pulse) begin
        start = (n == 3) || (n == 6);
        if (start) begin
          op   = 2'($urandom);
          src1 = $urandom;
          src2 = $urandom;
        end
      end
    end
    start  = 1'b0;
    f_prev = exp;
    s_prev = exp;
  endtask

  logic [31:0] corner [6];

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    src1   = '0;
    src2   = '0;
    f_prev = '0;
    s_prev = '0;
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
               32'h7FFFFFFF, 32'h0000FFFF};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(f_busy), 32'd0);
    check("rst done", 32'(f_done), 32'd0);
    check("rst res", f_res, 32'h0);
    check("rst res slow", s_res, 32'h0);

    do_op(2'b00, 32'h00012345, 32'h00010000, 1'b0);
    check("mul value", s_res, 32'h23450000);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("xuu max", s_res, 32'hFFFFFFFE);
    do_op(2'b10, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("xss -2", s_res, 32'hFFFFFFFF);
    do_op(2'b10, 32'h80000000, 32'h80000000, 1'b0);
    check("xss min*min", s_res, 32'h40000000);
    do_op(2'b10, 32'h80000000, 32'h00000001, 1'b0);
    check("xss min*1", s_res, 32'hFFFFFFFF);
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("xsu -1*max", s_res, 32'hFFFFFFFF);
    do_op(2'b11, 32'h00000002, 32'h80000000, 1'b0);
    check("xsu 2*2^31", s_res, 32'h00000001);

    do_op(2'b01, 32'h00010000, 32'h00010000, 1'b1);
    check("hs ignored", s_res, 32'h00000001);
    do_op(2'b01, 32'h00000003, 32'h00000005, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : $urandom;
      do_op(2'($urandom), a, b, 1'b0);
    end

    // Abort an operation in ACC cycle 2; no done may follow.
    start = 1'b1;
    op    = 2'b01;
    src1  = 32'h12345678;
    src2  = 32'h9ABCDEF0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy f", 32'(f_busy), 32'd0);
    check("abort busy s", 32'(s_busy), 32'd0);
    check("abort done f", 32'(f_done), 32'd0);
    check("abort res f", f_res, 32'h0);
    check("abort res s", s_res, 32'h0);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("abort no done f", 32'(f_done), 32'd0);
      check("abort no done s", 32'(s_done), 32'd0);
    end
    f_prev = '0;
    s_prev = '0;
    do_op(2'b10, 32'hFFFFFFFD, 32'h00000007, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
